// File: rtl/net_recv_event_extract.sv
// net_recv_event_extract
//
// Ingress front end for the NET_RECV controller stage. It splits each received
// frame into four independently handshaked event channels:
//   - hdr : the IPv4 header slice taken from the first beat
//   - seq : a per-frame sequence number
//   - len : the frame byte count
//   - pkt : the frame itself, forwarded beat by beat
// Each channel has a one-entry output register, so downstream barrier queues
// can drain the channels at different rates.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   s_pkt_*                  ingress AXI-Stream (tdata/tkeep/tlast/tvalid/tready)
//   m_hdr_*                  header slice channel (tdata/tvalid/tready)
//   m_seq_*                  sequence number channel (tdata/tvalid/tready)
//   m_len_*                  frame length channel (tdata/tvalid/tready)
//   m_pkt_*                  forwarded frame (tdata/tkeep/tlast/tvalid/tready)
//   short_cnt                saturating count of frames too short for the header
//
// States
//   ST_FIRST | next accepted beat is the first beat of a frame
//   ST_BODY  | inside a multi-beat frame, waiting for its remaining beats
module net_recv_event_extract #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH/8,
  parameter int HDR_OFFSET = 14,
  parameter int HDR_WIDTH  = 160,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [DATA_WIDTH-1:0] s_pkt_tdata,
  input  logic [KEEP_WIDTH-1:0] s_pkt_tkeep,
  input  logic                  s_pkt_tlast,
  input  logic                  s_pkt_tvalid,
  output logic                  s_pkt_tready,

  output logic [HDR_WIDTH-1:0]  m_hdr_tdata,
  output logic                  m_hdr_tvalid,
  input  logic                  m_hdr_tready,

  output logic [LEN_WIDTH-1:0]  m_seq_tdata,
  output logic                  m_seq_tvalid,
  input  logic                  m_seq_tready,

  output logic [LEN_WIDTH-1:0]  m_len_tdata,
  output logic                  m_len_tvalid,
  input  logic                  m_len_tready,

  output logic [DATA_WIDTH-1:0] m_pkt_tdata,
  output logic [KEEP_WIDTH-1:0] m_pkt_tkeep,
  output logic                  m_pkt_tlast,
  output logic                  m_pkt_tvalid,
  input  logic                  m_pkt_tready,

  output logic [15:0]           short_cnt
);

  localparam int HDR_BYTES     = HDR_WIDTH/8;
  localparam int HDR_LAST_BYTE = HDR_OFFSET + HDR_BYTES - 1;
  localparam int CNT_W         = $clog2(KEEP_WIDTH + 1);

  typedef enum logic {ST_FIRST, ST_BODY} state_t;

  state_t                state_q, state_d;
  logic                  rdy_en_q, rdy_en_d;

  logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
  logic                  hdr_vld_q, hdr_vld_d;
  logic [LEN_WIDTH-1:0]  seq_q, seq_d;
  logic                  seq_vld_q, seq_vld_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  len_vld_q, len_vld_d;
  logic [DATA_WIDTH-1:0] pkt_data_q, pkt_data_d;
  logic [KEEP_WIDTH-1:0] pkt_keep_q, pkt_keep_d;
  logic                  pkt_last_q, pkt_last_d;
  logic                  pkt_vld_q, pkt_vld_d;

  logic [LEN_WIDTH-1:0]  seq_ctr_q, seq_ctr_d;
  logic [LEN_WIDTH-1:0]  len_acc_q, len_acc_d;
  logic [15:0]           short_cnt_q, short_cnt_d;

  logic                  hdr_free, seq_free, len_free, pkt_free;
  logic                  accept;
  logic [HDR_WIDTH-1:0]  hdr_slice;
  logic [CNT_W-1:0]      beat_bytes;
  logic [LEN_WIDTH:0]    acc_sum;
  logic [LEN_WIDTH-1:0]  acc_sat;

  // A register is free when empty or being drained this cycle.
  assign hdr_free = !hdr_vld_q || m_hdr_tready;
  assign seq_free = !seq_vld_q || m_seq_tready;
  assign len_free = !len_vld_q || m_len_tready;
  assign pkt_free = !pkt_vld_q || m_pkt_tready;

  // rdy_en_q holds ready low until the first edge after reset release.
  // hdr/seq only matter for a first beat; len only matters for a last beat.
  assign s_pkt_tready = rdy_en_q && pkt_free
                      && (!s_pkt_tlast || len_free)
                      && ((state_q == ST_BODY) || (hdr_free && seq_free));
  assign accept = s_pkt_tvalid && s_pkt_tready;

  // Header slice with disabled bytes zeroed, so short frames carry no stale data.
  always_comb begin
    hdr_slice = '0;
    for (int i = 0; i < HDR_BYTES; i++) begin
      hdr_slice[8*i +: 8] = s_pkt_tkeep[HDR_OFFSET+i]
                          ? s_pkt_tdata[8*(HDR_OFFSET+i) +: 8] : 8'h00;
    end
  end

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + CNT_W'(s_pkt_tkeep[i]);
    end
  end

  // One extra bit catches the carry so the running length saturates.
  always_comb begin
    acc_sum = {1'b0, len_acc_q} + {{(LEN_WIDTH+1-CNT_W){1'b0}}, beat_bytes};
    acc_sat = acc_sum[LEN_WIDTH] ? '1 : acc_sum[LEN_WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    rdy_en_d    = 1'b1;
    hdr_d       = hdr_q;
    seq_d       = seq_q;
    len_d       = len_q;
    pkt_data_d  = pkt_data_q;
    pkt_keep_d  = pkt_keep_q;
    pkt_last_d  = pkt_last_q;
    seq_ctr_d   = seq_ctr_q;
    len_acc_d   = len_acc_q;
    short_cnt_d = short_cnt_q;
    hdr_vld_d   = hdr_vld_q && !m_hdr_tready;
    seq_vld_d   = seq_vld_q && !m_seq_tready;
    len_vld_d   = len_vld_q && !m_len_tready;
    pkt_vld_d   = pkt_vld_q && !m_pkt_tready;

    if (accept) begin
      pkt_data_d = s_pkt_tdata;
      pkt_keep_d = s_pkt_tkeep;
      pkt_last_d = s_pkt_tlast;
      pkt_vld_d  = 1'b1;

      if (state_q == ST_FIRST) begin
        hdr_d     = hdr_slice;
        hdr_vld_d = 1'b1;
        seq_d     = seq_ctr_q;
        seq_vld_d = 1'b1;
        seq_ctr_d = seq_ctr_q + LEN_WIDTH'(1);
        if (!s_pkt_tkeep[HDR_LAST_BYTE] && (short_cnt_q != 16'hFFFF)) begin
          short_cnt_d = short_cnt_q + 16'd1;
        end
      end

      if (s_pkt_tlast) begin
        len_d     = acc_sat;
        len_vld_d = 1'b1;
        len_acc_d = '0;
        state_d   = ST_FIRST;
      end else begin
        len_acc_d = acc_sat;
        state_d   = ST_BODY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_FIRST;
      rdy_en_q    <= 1'b0;
      hdr_q       <= '0;
      hdr_vld_q   <= 1'b0;
      seq_q       <= '0;
      seq_vld_q   <= 1'b0;
      len_q       <= '0;
      len_vld_q   <= 1'b0;
      pkt_data_q  <= '0;
      pkt_keep_q  <= '0;
      pkt_last_q  <= 1'b0;
      pkt_vld_q   <= 1'b0;
      seq_ctr_q   <= '0;
      len_acc_q   <= '0;
      short_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= rdy_en_d;
      hdr_q       <= hdr_d;
      hdr_vld_q   <= hdr_vld_d;
      seq_q       <= seq_d;
      seq_vld_q   <= seq_vld_d;
      len_q       <= len_d;
      len_vld_q   <= len_vld_d;
      pkt_data_q  <= pkt_data_d;
      pkt_keep_q  <= pkt_keep_d;
      pkt_last_q  <= pkt_last_d;
      pkt_vld_q   <= pkt_vld_d;
      seq_ctr_q   <= seq_ctr_d;
      len_acc_q   <= len_acc_d;
      short_cnt_q <= short_cnt_d;
    end
  end

  assign m_hdr_tdata  = hdr_q;
  assign m_hdr_tvalid = hdr_vld_q;
  assign m_seq_tdata  = seq_q;
  assign m_seq_tvalid = seq_vld_q;
  assign m_len_tdata  = len_q;
  assign m_len_tvalid = len_vld_q;
  assign m_pkt_tdata  = pkt_data_q;
  assign m_pkt_tkeep  = pkt_keep_q;
  assign m_pkt_tlast  = pkt_last_q;
  assign m_pkt_tvalid = pkt_vld_q;
  assign short_cnt    = short_cnt_q;

endmodule

// File: tb/tb_net_recv_event_extract.sv
// Testbench for net_recv_event_extract: directed steps followed by random
// frames with random consumer backpressure, checked against a frame-level
// reference model (per-channel expectation queues).
module tb_net_recv_event_extract;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int HW = 160;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_pkt_tdata = '0;
  logic [KW-1:0] s_pkt_tkeep = '0;
  logic          s_pkt_tlast = 1'b0;
  logic          s_pkt_tvalid = 1'b0;
  logic          s_pkt_tready;
  logic [HW-1:0] m_hdr_tdata;
  logic          m_hdr_tvalid, m_hdr_tready;
  logic [LW-1:0] m_seq_tdata;
  logic          m_seq_tvalid, m_seq_tready;
  logic [LW-1:0] m_len_tdata;
  logic          m_len_tvalid, m_len_tready;
  logic [DW-1:0] m_pkt_tdata;
  logic [KW-1:0] m_pkt_tkeep;
  logic          m_pkt_tlast, m_pkt_tvalid, m_pkt_tready;
  logic [15:0]   short_cnt;

  // consumer readies: directed values or random values
  logic rand_rdy = 1'b0;
  logic d_hdr = 1'b1, d_seq = 1'b1, d_len = 1'b1, d_pkt = 1'b1;
  logic r_hdr = 1'b1, r_seq = 1'b1, r_len = 1'b1, r_pkt = 1'b1;
  assign m_hdr_tready = rand_rdy ? r_hdr : d_hdr;
  assign m_seq_tready = rand_rdy ? r_seq : d_seq;
  assign m_len_tready = rand_rdy ? r_len : d_len;
  assign m_pkt_tready = rand_rdy ? r_pkt : d_pkt;

  always #5 clk = ~clk;

  net_recv_event_extract dut (
    .clk          (clk),
    .rst          (rst),
    .s_pkt_tdata  (s_pkt_tdata),
    .s_pkt_tkeep  (s_pkt_tkeep),
    .s_pkt_tlast  (s_pkt_tlast),
    .s_pkt_tvalid (s_pkt_tvalid),
    .s_pkt_tready (s_pkt_tready),
    .m_hdr_tdata  (m_hdr_tdata),
    .m_hdr_tvalid (m_hdr_tvalid),
    .m_hdr_tready (m_hdr_tready),
    .m_seq_tdata  (m_seq_tdata),
    .m_seq_tvalid (m_seq_tvalid),
    .m_seq_tready (m_seq_tready),
    .m_len_tdata  (m_len_tdata),
    .m_len_tvalid (m_len_tvalid),
    .m_len_tready (m_len_tready),
    .m_pkt_tdata  (m_pkt_tdata),
    .m_pkt_tkeep  (m_pkt_tkeep),
    .m_pkt_tlast  (m_pkt_tlast),
    .m_pkt_tvalid (m_pkt_tvalid),
    .m_pkt_tready (m_pkt_tready),
    .short_cnt    (short_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [HW-1:0] q_hdr[$];
  logic [LW-1:0] q_seq[$];
  logic [LW-1:0] q_len[$];
  logic [DW-1:0] q_pdata[$];
  logic [KW-1:0] q_pkeep[$];
  logic          q_plast[$];
  bit            m_first = 1'b1;
  int            m_len   = 0;
  logic [LW-1:0] m_seq   = '0;
  int            m_short = 0;

  task automatic model_reset();
    q_hdr.delete(); q_seq.delete(); q_len.delete();
    q_pdata.delete(); q_pkeep.delete(); q_plast.delete();
    m_first = 1'b1; m_len = 0; m_seq = '0; m_short = 0;
  endtask

  // Frame bytes are contiguous from byte 0, so the byte count decides
  // which header bytes exist and whether the frame is short.
  task automatic model_accept(input logic [DW-1:0] data, input logic [KW-1:0] keep, input logic last);
    int nb;
    logic [HW-1:0] h;
    nb = $countones(keep);
    if (m_first) begin
      h = '0;
      for (int b = 0; b < HW/8; b++)
        if (14 + b < nb) h[8*b +: 8] = data[8*(14+b) +: 8];
      q_hdr.push_back(h);
      q_seq.push_back(m_seq);
      m_seq = m_seq + 32'd1;
      if (nb < 14 + HW/8 && m_short < 65535) m_short++;
    end
    m_len += nb;
    q_pdata.push_back(data); q_pkeep.push_back(keep); q_plast.push_back(last);
    if (last) begin
      q_len.push_back(LW'(m_len));
      m_len = 0;
      m_first = 1'b1;
    end else begin
      m_first = 1'b0;
    end
  endtask

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    logic [HW-1:0] eh;
    logic [LW-1:0] es;
    logic [DW-1:0] ed;
    logic [KW-1:0] ek;
    logic          el;
    if (rst) begin
      if (m_hdr_tvalid && m_hdr_tready) begin
        if (q_hdr.size() > 0) eh = q_hdr.pop_front(); else eh = 'x;
        check("mon_hdr", DW'(m_hdr_tdata), DW'(eh));
      end
      if (m_seq_tvalid && m_seq_tready) begin
        if (q_seq.size() > 0) es = q_seq.pop_front(); else es = 'x;
        check("mon_seq", DW'(m_seq_tdata), DW'(es));
      end
      if (m_len_tvalid && m_len_tready) begin
        if (q_len.size() > 0) es = q_len.pop_front(); else es = 'x;
        check("mon_len", DW'(m_len_tdata), DW'(es));
      end
      if (m_pkt_tvalid && m_pkt_tready) begin
        if (q_pdata.size() > 0) begin
          ed = q_pdata.pop_front(); ek = q_pkeep.pop_front(); el = q_plast.pop_front();
        end else begin
          ed = 'x; ek = 'x; el = 1'bx;
        end
        check("mon_pkt_data", m_pkt_tdata, ed);
        check("mon_pkt_keep", DW'(m_pkt_tkeep), DW'(ek));
        check("mon_pkt_last", DW'(m_pkt_tlast), DW'(el));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    r_hdr = ($urandom_range(3) != 0);
    r_seq = ($urandom_range(3) != 0);
    r_len = ($urandom_range(3) != 0);
    r_pkt = ($urandom_range(3) != 0);
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int w = 0; w < DW/32; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [KW-1:0] keep_of(input int n);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i < n; i++) k[i] = 1'b1;
    return k;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_beat(input logic [DW-1:0] data, input logic [KW-1:0] keep,
                           input logic last, output int waited);
    s_pkt_tdata = data; s_pkt_tkeep = keep; s_pkt_tlast = last; s_pkt_tvalid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (s_pkt_tready) begin
        model_accept(data, keep, last);
        @(posedge clk); #1;
        break;
      end
      waited++;
      if (waited >= 300) begin
        check("accept_timeout", DW'(s_pkt_tready), DW'(1));
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    s_pkt_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int nbeats, input int last_bytes);
    int w;
    for (int b = 0; b < nbeats; b++)
      send_beat(rand_data(), (b == nbeats-1) ? keep_of(last_bytes) : '1, b == nbeats-1, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    s_pkt_tvalid = 1'b0;
    model_reset();
    #1;
    check("rst_valids", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(0));
    check("rst_ready", DW'(s_pkt_tready), DW'(0));
    check("rst_data", m_pkt_tdata | DW'(m_hdr_tdata) | DW'(m_seq_tdata) | DW'(m_len_tdata), DW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_after", DW'(s_pkt_tready), DW'(1));
    @(posedge clk); #1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic [HW-1:0] eh;
    int w, tot;

    #2;
    check("init_valids", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(0));
    check("init_ready", DW'(s_pkt_tready), DW'(0));
    check("init_pkt", m_pkt_tdata | DW'(m_pkt_tkeep) | DW'(m_pkt_tlast), DW'(0));
    check("init_short", DW'(short_cnt), DW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 check("ready_before_edge", DW'(s_pkt_tready), DW'(0));
    @(negedge clk);
    check("ready_first_edge", DW'(s_pkt_tready), DW'(1));
    @(posedge clk); #1;

    // single 64-byte frame
    d = rand_data();
    send_beat(d, '1, 1'b1, w);
    @(negedge clk);
    check("s1_valids", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(4'hF));
    check("s1_hdr", DW'(m_hdr_tdata), DW'(d[14*8 +: HW]));
    check("s1_seq", DW'(m_seq_tdata), DW'(0));
    check("s1_len", DW'(m_len_tdata), DW'(64));
    check("s1_pkt", m_pkt_tdata, d);
    check("s1_last", DW'(m_pkt_tlast), DW'(1));
    @(negedge clk);
    check("s1_one_cycle", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(0));
    @(posedge clk); #1;

    // 3-beat frame: 64 + 64 + 16 bytes, then a second frame
    do_reset();
    send_beat(rand_data(), '1, 1'b0, w);
    @(negedge clk);
    check("s2_hdr_lat", DW'(m_hdr_tvalid), DW'(1));
    check("s2_seq0", DW'(m_seq_tdata), DW'(0));
    check("s2_no_len", DW'(m_len_tvalid), DW'(0));
    @(posedge clk); #1;
    send_beat(rand_data(), '1, 1'b0, w);
    send_beat(rand_data(), keep_of(16), 1'b1, w);
    @(negedge clk);
    check("s2_len_vld", DW'(m_len_tvalid), DW'(1));
    check("s2_len", DW'(m_len_tdata), DW'(144));
    @(posedge clk); #1;
    send_beat(rand_data(), '1, 1'b1, w);
    @(negedge clk);
    check("s2_seq1", DW'(m_seq_tdata), DW'(1));
    @(posedge clk); #1;

    // 20-byte frame: partial header, short count
    do_reset();
    d = rand_data();
    send_beat(d, keep_of(20), 1'b1, w);
    @(negedge clk);
    eh = '0;
    eh[47:0] = d[14*8 +: 48];
    check("s3_hdr", DW'(m_hdr_tdata), DW'(eh));
    check("s3_short", DW'(short_cnt), DW'(1));
    check("s3_len", DW'(m_len_tdata), DW'(20));
    check("s3_pkt", m_pkt_tdata, d);
    check("s3_keep", DW'(m_pkt_tkeep), DW'(20'hFFFFF));
    @(posedge clk); #1;

    // len consumer stalled over two single-beat frames
    d_len = 1'b0;
    send_beat(rand_data(), '1, 1'b1, w);
    d = rand_data();
    s_pkt_tdata = d; s_pkt_tkeep = '1; s_pkt_tlast = 1'b1; s_pkt_tvalid = 1'b1;
    @(negedge clk);
    check("s4_stall0", DW'(s_pkt_tready), DW'(0));
    check("s4_len_held", DW'(m_len_tdata), DW'(64));
    @(posedge clk); #1;
    @(negedge clk);
    check("s4_stall1", DW'(s_pkt_tready), DW'(0));
    check("s4_drained", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(4'b0010));
    @(posedge clk); #1;
    d_len = 1'b1;
    send_beat(d, '1, 1'b1, w);
    check("s4_release", DW'(w), DW'(0));
    @(negedge clk);
    check("s4_pkt2", m_pkt_tdata, d);
    @(posedge clk); #1;

    // throughput: back-to-back single-beat frames
    tot = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(rand_data(), keep_of($urandom_range(1, 64)), 1'b1, w);
      tot += w;
    end
    check("tput_waits", DW'(tot), DW'(0));

    // reset during beat 2 of a 4-beat frame
    send_beat(rand_data(), '1, 1'b0, w);
    s_pkt_tdata = rand_data(); s_pkt_tkeep = '1; s_pkt_tlast = 1'b0; s_pkt_tvalid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    s_pkt_tvalid = 1'b0;
    model_reset();
    #1;
    check("s5_valids", DW'({m_hdr_tvalid, m_seq_tvalid, m_len_tvalid, m_pkt_tvalid}), DW'(0));
    check("s5_ready", DW'(s_pkt_tready), DW'(0));
    check("s5_pkt", m_pkt_tdata, DW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    send_beat(rand_data(), '1, 1'b1, w);
    @(negedge clk);
    check("s5_seq", DW'(m_seq_tdata), DW'(0));
    check("s5_len", DW'(m_len_tdata), DW'(64));
    @(posedge clk); #1;

    // sequence wrap via preloaded counter (idle cycle, no accept)
    @(negedge clk);
    force dut.seq_ctr_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.seq_ctr_q;
    m_seq = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    send_beat(rand_data(), '1, 1'b1, w);
    @(negedge clk);
    check("s6_seq_max", DW'(m_seq_tdata), DW'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    send_beat(rand_data(), keep_of(40), 1'b1, w);
    @(negedge clk);
    check("s6_seq_wrap", DW'(m_seq_tdata), DW'(0));
    @(posedge clk); #1;

    // random frames with random backpressure
    rand_rdy = 1'b1;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(3) == 0) begin
        @(posedge clk); #1;
      end
      send_frame($urandom_range(1, 4), $urandom_range(1, 64));
    end
    rand_rdy = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (q_hdr.size() + q_seq.size() + q_len.size() + q_pdata.size() == 0) break;
      @(negedge clk);
    end
    check("drain_hdr", DW'(q_hdr.size()), DW'(0));
    check("drain_seq", DW'(q_seq.size()), DW'(0));
    check("drain_len", DW'(q_len.size()), DW'(0));
    check("drain_pkt", DW'(q_pdata.size()), DW'(0));
    check("final_short", DW'(short_cnt), DW'(m_short));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
